bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master arbiter and sequencer for the MCU system bus. It round-robins CPU (m0) and DMA (m1)
//  requests onto one shared bus and decodes addr[31:16] into four regions. It inserts
//  per-region wait states, muxes read data back, and returns a one-cycle ack/err.
//  Sits between cpu/dma and the bram/sram/flash/mmio slaves.
// PARAMETERS
//  BRAM_WS        0    wait states, region 16'h0000
//  SRAM_WS        1    wait states, region 16'h0001
//  FLASH_WS       2    wait states, region 16'h0002 (flash_ready still honoured)
//  MMIO_WS        0    wait states, region 16'h0003
//  TIMEOUT_CYCLES 255  max ACCESS cycles before abort (only with BUS_TIMEOUT_EN)
// PORTS
//  clk          in   1   single system clock, all logic rising-edge
//  n_reset      in   1   asynchronous, active-low reset
//  mN_req       in   1   master N (N=0,1) request; held until mN_ack
//  mN_write     in   1   1=write, 0=read; held with req
//  mN_addr      in   32  byte address; held with req
//  mN_wdata     in   32  write data; held with req
//  mN_rdata     out  32  registered read data, valid while mN_ack=1
//  mN_ack       out  1   one-cycle completion pulse
//  mN_err       out  1   with ack: unmapped address or timeout
//  s_addr       out  32  address of granted master
//  s_wdata      out  32  write data of granted master
//  s_read       out  1   read strobe, high through ACCESS
//  s_write      out  1   write strobe, high through ACCESS
//  s_sel        out  4   one-hot region select {mmio,flash,sram,bram}
//  bram_rdata, sram_rdata, flash_rdata, mmio_rdata  in 32  slave read data
//  flash_ready  in   1   0 stalls completion of flash-region accesses
//  grant        out  2   one-hot current owner {m1,m0}; 0 when idle
// BEHAVIOUR
//  - Reset (async, n_reset=0): state=IDLE.
//    Outputs reset: all acks, errs, strobes, s_sel and grant = 0; rdata = 0; s_addr/s_wdata = 0.
//    Last-grant pointer resets to m1, so m0 wins the first tie.
//  - Reset mid-transaction aborts immediately: no ack is issued and strobes drop asynchronously.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: when any req=1, latch the winner's addr/wdata/write and set grant.
//    Load wait counter wc with the region WS.
//    - Only one req: that master wins.
//    - Both: the master not granted last wins. The pointer updates on every grant.
//    - Unmapped region (addr[31:16] > 16'h0003): go straight to DONE with err=1.
//      No strobe and no s_sel are driven.
//  - ACCESS: s_sel, s_read/s_write and s_addr/s_wdata are stable for the whole state.
//    - wc decrements each cycle while nonzero.
//    - Exit to DONE when wc==0 and (region != flash or flash_ready=1).
//    - On exit, register rdata from the selected slave (reads only; writes leave rdata 0).
//  - DONE: assert mN_ack of the owner for exactly one cycle, with err if flagged.
//    Strobes and s_sel are 0. grant clears and the FSM returns to IDLE.
//    A still-high req from the other master is arbitrated on the next IDLE cycle.
//  - Latency (req seen in IDLE at edge 0): ACCESS from edge 1; ack high after edge 2+WS.
//    Throughput: at most one transaction per 3+WS cycles.
//  - A master deasserting req before ack is a protocol violation; the arbiter completes anyway.
//  - The non-owner's ack/err/rdata are 0 at all times.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//    - A cycle counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS.
//    - When it reaches TIMEOUT_CYCLES, go to DONE with err=1 and rdata=0.
//    - This covers a stuck flash_ready=0.
//  BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for flash_ready.
// TESTING
//  1. m0 read of 32'h0000_0010, bram_rdata=32'hDEADBEEF -> s_read in cycle 1, m0_ack in cycle 2,
//     m0_rdata=32'hDEADBEEF, err=0.
//  2. m0 and m1 both raise req in the same cycle after reset, both held high -> grant=01, then 10, then 01.
//     Acks strictly alternate and are never simultaneous.
//  3. m1 write to 32'h0001_0004 with SRAM_WS=1 -> s_write high for 2 cycles, s_sel=0010, m1_ack at cycle 3.
//  4. m0 read of 32'h0002_0000 with flash_ready=0 for 10 cycles -> ack 1 cycle after flash_ready rises.
//     With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4: ack with err=1 instead.
//  5. m0 read of 32'h0004_0000 -> no strobe, s_sel=0, m0_ack=1 with m0_err=1 at cycle 1.
//  6. Pulse n_reset low during the ACCESS of an SRAM write -> all outputs 0 at once, no ack.
//     A new request after release completes normally.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// System-bus bundle between the CPU/DMA masters, the bus_arbiter and the region slaves.
// The arbiter connects through the slave modport; the master modport is the environment's view.
interface bus_arbiter_if;
  logic        m0_req;
  logic        m0_write;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_err;

  logic        m1_req;
  logic        m1_write;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        m1_err;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_read;
  logic        s_write;
  logic [3:0]  s_sel;
  logic [31:0] bram_rdata;
  logic [31:0] sram_rdata;
  logic [31:0] flash_rdata;
  logic [31:0] mmio_rdata;
  logic        flash_ready;

  logic [1:0]  grant;

  modport slave (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    input  bram_rdata, sram_rdata, flash_rdata, mmio_rdata, flash_ready,
    output m0_rdata, m0_ack, m0_err,
    output m1_rdata, m1_ack, m1_err,
    output s_addr, s_wdata, s_read, s_write, s_sel, grant
  );

  modport master (
    output m0_req, m0_write, m0_addr, m0_wdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    output bram_rdata, sram_rdata, flash_rdata, mmio_rdata, flash_ready,
    input  m0_rdata, m0_ack, m0_err,
    input  m1_rdata, m1_ack, m1_err,
    input  s_addr, s_wdata, s_read, s_write, s_sel, grant
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter/sequencer: region decode, wait states, read-data return, ack/err.
// Optional ACCESS timeout abort is compiled in when BUS_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int unsigned BRAM_WS        = 0,
  parameter int unsigned SRAM_WS        = 1,
  parameter int unsigned FLASH_WS       = 2,
  parameter int unsigned MMIO_WS        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          n_reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0]  REGION_FLASH = 2'd2;
  localparam int unsigned WS_MAX_A = (BRAM_WS > SRAM_WS) ? BRAM_WS : SRAM_WS;
  localparam int unsigned WS_MAX_B = (FLASH_WS > MMIO_WS) ? FLASH_WS : MMIO_WS;
  localparam int unsigned WS_MAX   = (WS_MAX_A > WS_MAX_B) ? WS_MAX_A : WS_MAX_B;
  localparam int unsigned WC_W     = $clog2(WS_MAX + 2);

  state_t          state_q;
  logic            owner_q;   // 1 = m1 owns the current transaction
  logic            last_q;    // owner of the most recent grant
  logic            write_q;
  logic [1:0]      region_q;
  logic [WC_W-1:0] wc_q;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TC_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TC_W-1:0] tc_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  logic            win_m1;
  logic            win_write;
  logic [31:0]     win_addr;
  logic [31:0]     win_wdata;
  logic            win_mapped;
  logic [1:0]      win_region;
  logic [WC_W-1:0] win_ws;
  logic [31:0]     slave_rdata;
  logic            access_done;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    win_m1      = bus.m1_req & (~bus.m0_req | ~last_q);
    win_write   = win_m1 ? bus.m1_write : bus.m0_write;
    win_addr    = win_m1 ? bus.m1_addr  : bus.m0_addr;
    win_wdata   = win_m1 ? bus.m1_wdata : bus.m0_wdata;
    win_mapped  = (win_addr[31:18] == 14'd0);
    win_region  = win_addr[17:16];
    win_ws      = WC_W'(BRAM_WS);
    slave_rdata = bus.bram_rdata;
    case (win_region)
      2'd1:    win_ws = WC_W'(SRAM_WS);
      2'd2:    win_ws = WC_W'(FLASH_WS);
      2'd3:    win_ws = WC_W'(MMIO_WS);
      default: win_ws = WC_W'(BRAM_WS);
    endcase
    case (region_q)
      2'd1:    slave_rdata = bus.sram_rdata;
      2'd2:    slave_rdata = bus.flash_rdata;
      2'd3:    slave_rdata = bus.mmio_rdata;
      default: slave_rdata = bus.bram_rdata;
    endcase
    access_done = (wc_q == '0) && ((region_q != REGION_FLASH) || bus.flash_ready);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      write_q      <= 1'b0;
      region_q     <= 2'd0;
      wc_q         <= '0;
`ifdef BUS_TIMEOUT_EN
      tc_q         <= '0;
`endif
      bus.m0_ack   <= 1'b0;
      bus.m0_err   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_ack   <= 1'b0;
      bus.m1_err   <= 1'b0;
      bus.m1_rdata <= '0;
      bus.s_addr   <= '0;
      bus.s_wdata  <= '0;
      bus.s_read   <= 1'b0;
      bus.s_write  <= 1'b0;
      bus.s_sel    <= 4'b0000;
      bus.grant    <= 2'b00;
    end else begin
      // Completion outputs are single-cycle pulses; rdata is only nonzero alongside ack.
      bus.m0_ack   <= 1'b0;
      bus.m0_err   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_ack   <= 1'b0;
      bus.m1_err   <= 1'b0;
      bus.m1_rdata <= '0;

      unique case (state_q)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            owner_q     <= win_m1;
            last_q      <= win_m1;
            bus.grant   <= win_m1 ? 2'b10 : 2'b01;
            write_q     <= win_write;
            region_q    <= win_region;
            wc_q        <= win_ws;
            bus.s_addr  <= win_addr;
            bus.s_wdata <= win_wdata;
`ifdef BUS_TIMEOUT_EN
            tc_q        <= '0;
`endif
            if (win_mapped) begin
              bus.s_sel   <= 4'b0001 << win_region;
              bus.s_read  <= ~win_write;
              bus.s_write <= win_write;
              state_q     <= ACCESS;
            end else begin
              // Unmapped: complete with error without ever touching a slave.
              bus.m0_ack <= ~win_m1;
              bus.m0_err <= ~win_m1;
              bus.m1_ack <= win_m1;
              bus.m1_err <= win_m1;
              state_q    <= DONE;
            end
          end
        end

        ACCESS: begin
          if (access_done) begin
            bus.s_sel   <= 4'b0000;
            bus.s_read  <= 1'b0;
            bus.s_write <= 1'b0;
            state_q     <= DONE;
            if (owner_q) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_rdata <= write_q ? 32'h0 : slave_rdata;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_rdata <= write_q ? 32'h0 : slave_rdata;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (tc_q == TC_W'(TIMEOUT_CYCLES)) begin
            bus.s_sel   <= 4'b0000;
            bus.s_read  <= 1'b0;
            bus.s_write <= 1'b0;
            state_q     <= DONE;
            bus.m0_ack  <= ~owner_q;
            bus.m0_err  <= ~owner_q;
            bus.m1_ack  <= owner_q;
            bus.m1_err  <= owner_q;
          end
`endif
          else begin
            if (wc_q != '0) begin
              wc_q <= wc_q - WC_W'(1);
            end
`ifdef BUS_TIMEOUT_EN
            tc_q <= tc_q + TC_W'(1);
`endif
          end
        end

        DONE: begin
          bus.grant <= 2'b00;
          state_q   <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: drivers queue expected responses, a negedge monitor checks them
// against a rule-level model of arbitration order, access length, bus drive and completion data.
module tb_bus_arbiter;

  localparam int BRAM_WS  = 0;
  localparam int SRAM_WS  = 1;
  localparam int FLASH_WS = 2;
  localparam int MMIO_WS  = 0;
`ifdef BUS_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 4;
`else
  localparam int TIMEOUT_CYCLES = 255;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    int          region;   // 0..3 mapped, 4 unmapped
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  logic clk;
  logic n_reset;
  logic flash_force;
  int   n_cmp = 0;
  int   n_bad = 0;
  txn_t q0[$];
  txn_t q1[$];

  bus_arbiter_if bus();

  bus_arbiter #(
    .BRAM_WS(BRAM_WS), .SRAM_WS(SRAM_WS), .FLASH_WS(FLASH_WS), .MMIO_WS(MMIO_WS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] slave_data(input int r, input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + (32'h0101_0101 * 32'(r + 1));
  endfunction

  function automatic int region_of(input logic [31:0] a);
    return (a[31:16] < 16'd4) ? int'(a[17:16]) : 4;
  endfunction

  function automatic int ws_of(input int r);
    case (r)
      0:       return BRAM_WS;
      1:       return SRAM_WS;
      2:       return FLASH_WS;
      default: return MMIO_WS;
    endcase
  endfunction

  function automatic logic [1:0] onehot(input int o);
    return (o == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [159:0] out_vec();
    return 160'({bus.m0_rdata, bus.m1_rdata, bus.s_addr, bus.s_wdata, bus.m0_ack, bus.m0_err,
                 bus.m1_ack, bus.m1_err, bus.s_read, bus.s_write, bus.s_sel, bus.grant});
  endfunction

  // Slaves answer combinationally from the presented address, each region with its own pattern.
  assign bus.bram_rdata  = slave_data(0, bus.s_addr);
  assign bus.sram_rdata  = slave_data(1, bus.s_addr);
  assign bus.flash_rdata = slave_data(2, bus.s_addr);
  assign bus.mmio_rdata  = slave_data(3, bus.s_addr);

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t make_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    txn_t t;
    t.addr   = addr;
    t.wdata  = wd;
    t.write  = wr;
    t.region = region_of(addr);
    t.err    = (t.region == 4);
    t.rdata  = (t.region == 4 || wr) ? 32'h0 : slave_data(t.region, addr);
    return t;
  endfunction

  // Called at a negedge; returns at the negedge on which the ack was seen.
  task automatic do_txn(input int m, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    int   cnt;
    logic got;
    if (m == 0) begin
      q0.push_back(make_txn(addr, wr, wd));
      bus.m0_addr = addr; bus.m0_write = wr; bus.m0_wdata = wd; bus.m0_req = 1'b1;
    end else begin
      q1.push_back(make_txn(addr, wr, wd));
      bus.m1_addr = addr; bus.m1_write = wr; bus.m1_wdata = wd; bus.m1_req = 1'b1;
    end
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 600) begin
      @(negedge clk);
      cnt++;
      got = (m == 0) ? bus.m0_ack : bus.m1_ack;
    end
    if (!got) check($sformatf("ack_wait_m%0d", m), 160'(got), 160'(1));
    if (m == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  task automatic complete(input int own, input logic to);
    txn_t t;
    logic [31:0] rd;
    logic        er;
    if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: completion for m%0d with nothing expected", own);
      return;
    end
    if (own == 0) t = q0.pop_front();
    else          t = q1.pop_front();
    er = t.err | to;
    rd = to ? 32'h0 : t.rdata;
    check($sformatf("resp_m%0d_%0h", own, t.addr),
          160'({bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err, bus.m1_rdata, bus.m0_rdata}),
          (own == 0) ? 160'({2'b01, 1'b0, er, 32'h0, rd}) : 160'({2'b10, er, 1'b0, rd, 32'h0}));
  endtask

  // Request snapshot as the arbiter saw it on the last rising edge.
  logic [1:0] req_snap;
  always @(posedge clk) req_snap <= {bus.m1_req, bus.m0_req};

  // Flash readiness changes just after a rising edge so monitor and arbiter see the same value.
  always @(posedge clk) begin
    #1;
    if (!flash_force) bus.flash_ready = ($urandom_range(0, 3) != 0);
  end

  int         k;
  logic       pend;
  logic       pend_to;
  int         last_owner;
  logic [1:0] prev_grant;

  always @(negedge clk) begin : monitor
    logic       strobe;
    logic [1:0] ack;
    int         own;
    int         idx;
    logic       ok;
    txn_t       t;
    if (!n_reset) begin
      k = 0; pend = 1'b0; pend_to = 1'b0; last_owner = 1; prev_grant = 2'b00;
    end else begin
      ack    = {bus.m1_ack, bus.m0_ack};
      strobe = bus.s_read | bus.s_write;
      if (bus.grant != 2'b00 && prev_grant == 2'b00) begin
        own = (req_snap == 2'b11) ? (1 - last_owner) : (req_snap[1] ? 1 : 0);
        check("grant_owner", 160'(bus.grant), 160'(onehot(own)));
        last_owner = own;
        k = 0; pend = 1'b0; pend_to = 1'b0;
      end
      own = last_owner;
      if (pend) begin
        check("done_strobe", 160'(strobe), 160'(0));
        complete(own, pend_to);
        pend = 1'b0;
      end else if (strobe) begin
        check("access_ack", 160'(ack), 160'(0));
        if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL access_unexpected: strobe for m%0d with nothing queued", own);
        end else begin
          t = (own == 0) ? q0[0] : q1[0];
          check("bus_drive",
                160'({bus.s_sel, bus.s_read, bus.s_write, bus.s_addr, t.write ? bus.s_wdata : 32'h0}),
                160'({4'(4'b0001 << t.region), ~t.write, t.write, t.addr, t.write ? t.wdata : 32'h0}));
          idx = k;
          ok  = (idx >= ws_of(t.region)) && (t.region != 2 || bus.flash_ready);
          if (ok) pend = 1'b1;
`ifdef BUS_TIMEOUT_EN
          else if (idx == TIMEOUT_CYCLES) begin pend = 1'b1; pend_to = 1'b1; end
`endif
          k++;
        end
      end else if (ack != 2'b00) begin
        t = (own == 0 && q0.size() != 0) ? q0[0] : ((own == 1 && q1.size() != 0) ? q1[0] : t);
        if (t.region == 4) complete(own, 1'b0);
        else check("ack_without_access", 160'(ack), 160'(0));
      end else begin
        check("quiet_outputs", 160'({bus.m0_err, bus.m1_err, bus.m0_rdata, bus.m1_rdata}), 160'(0));
      end
      prev_grant = bus.grant;
    end
  end

  initial begin : watchdog
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stimulus
    int cnt;
    n_reset     = 1'b0;
    flash_force = 1'b1;
    bus.flash_ready = 1'b1;
    bus.m0_req = 1'b0; bus.m0_write = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_write = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 160'(0));
    n_reset = 1'b1;

    // Simultaneous requests held high: m0 first, then strict alternation.
    fork
      begin
        do_txn(0, 32'h0000_0010, 1'b0, 32'h0);
        do_txn(0, 32'h0000_0020, 1'b0, 32'h0);
      end
      begin
        do_txn(1, 32'h0001_0004, 1'b1, 32'hCAFE_F00D);
        do_txn(1, 32'h0003_0008, 1'b0, 32'h0);
      end
    join

    // Unmapped regions, read and write.
    do_txn(0, 32'h0004_0000, 1'b0, 32'h0);
    do_txn(1, 32'hFFFF_1234, 1'b1, 32'h1234_5678);

    // Flash stalled by flash_ready for ten cycles.
    @(posedge clk);
    #1 bus.flash_ready = 1'b0;
    @(negedge clk);
    fork
      do_txn(0, 32'h0002_0000, 1'b0, 32'h0);
      begin
        repeat (10) @(posedge clk);
        #1 bus.flash_ready = 1'b1;
      end
    join

    // Reset pulse in the middle of an SRAM write access.
    q1.push_back(make_txn(32'h0001_0040, 1'b1, 32'hA5A5_5A5A));
    bus.m1_addr = 32'h0001_0040; bus.m1_write = 1'b1; bus.m1_wdata = 32'hA5A5_5A5A; bus.m1_req = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.s_write && cnt < 20);
    check("sram_write_started", 160'(bus.s_write), 160'(1));
    #2 n_reset = 1'b0;
    #1 check("reset_abort", out_vec(), 160'(0));
    bus.m1_req = 1'b0;
    q1.delete();
    @(negedge clk);
    check("reset_hold", out_vec(), 160'(0));
    #2 n_reset = 1'b1;
    @(negedge clk);
    do_txn(1, 32'h0001_0004, 1'b1, 32'h0BAD_CAFE);

    // Randomised traffic from both masters with random flash readiness.
    flash_force = 1'b0;
    @(negedge clk);
    fork
      for (int i = 0; i < 30; i++) begin
        logic [15:0] hi;
        int          r;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        r  = $urandom_range(0, 4);
        hi = (r < 4) ? 16'(r) : 16'($urandom_range(4, 16'hFFFF));
        do_txn(0, {hi, 16'($urandom)}, 1'($urandom_range(0, 1)), $urandom);
      end
      for (int j = 0; j < 30; j++) begin
        logic [15:0] hi;
        int          r;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        r  = $urandom_range(0, 4);
        hi = (r < 4) ? 16'(r) : 16'($urandom_range(4, 16'hFFFF));
        do_txn(1, {hi, 16'($urandom)}, 1'($urandom_range(0, 1)), $urandom);
      end
    join

    repeat (5) @(negedge clk);
    check("q0_drained", 160'(q0.size()), 160'(0));
    check("q1_drained", 160'(q1.size()), 160'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
